// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the FIFO read-side packer.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PACK_NUM   = 4;

    // Ceiling log2, usable in constant expressions for counter widths.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << res) < value) begin
                res = res + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops narrow entries from the FIFO read port and packs PACK_NUM of them into
// one wide word on a valid/ready interface; flush emits a partial word.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PACK_NUM   = DEF_PACK_NUM,
    localparam int OUT_WIDTH = DATA_WIDTH * PACK_NUM
) (
    input  logic                  rdclk,
    input  logic                  rd_rst,
    input  logic                  fifo_empty,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  flush,
    output logic [OUT_WIDTH-1:0]  pk_data,
    output logic [PACK_NUM-1:0]   pk_keep,
    output logic                  pk_valid,
    input  logic                  pk_ready
);

    localparam int CNT_W = clog2(PACK_NUM) + 1;

    logic [CNT_W-1:0] iss_cnt;
    logic [CNT_W-1:0] fill_cnt;
    logic             flush_pend;
    logic             rd_vld;
    logic             handshake;
    logic             flush_hit;
    logic             flush_done;

    // Pop only while the word is still being gathered and no flush is draining it.
    assign rd_en = !rd_rst && !fifo_empty && !pk_valid && !flush_pend &&
                   (iss_cnt < CNT_W'(PACK_NUM));

    assign handshake  = pk_valid && pk_ready;
    // A flush matters only if something is held or in flight and no word is presented.
    assign flush_hit  = flush && !pk_valid && ((fill_cnt != '0) || (iss_cnt != '0));
    // Every issued pop has landed, so the partial word can go out.
    assign flush_done = flush_pend && !pk_valid && (iss_cnt == fill_cnt) && (fill_cnt != '0);

    // Control state: counters, read-valid pipeline, flush pending and output valid.
    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            iss_cnt    <= '0;
            fill_cnt   <= '0;
            flush_pend <= 1'b0;
            rd_vld     <= 1'b0;
            pk_valid   <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                iss_cnt <= iss_cnt + CNT_W'(1);
            end
            if (rd_vld) begin
                fill_cnt <= fill_cnt + CNT_W'(1);
                if (fill_cnt == CNT_W'(PACK_NUM - 1)) begin
                    pk_valid <= 1'b1;
                end
            end
            if (flush_hit) begin
                flush_pend <= 1'b1;
            end
            if (flush_done) begin
                pk_valid <= 1'b1;
            end
            if (handshake) begin
                pk_valid   <= 1'b0;
                iss_cnt    <= '0;
                fill_cnt   <= '0;
                flush_pend <= 1'b0;
            end
        end
    end

    // Lane write decode: returning data lands in lane fill_cnt and marks its keep bit.
    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            pk_data <= '0;
            pk_keep <= '0;
        end else begin
            for (int i = 0; i < PACK_NUM; i++) begin
                if (rd_vld && (fill_cnt == CNT_W'(i))) begin
                    pk_data[i*DATA_WIDTH +: DATA_WIDTH] <= data_out;
                    pk_keep[i]                          <= 1'b1;
                end
            end
            if (rd_vld && (fill_cnt == CNT_W'(PACK_NUM - 1))) begin
                pk_keep <= '1;
            end
            if (handshake) begin
                pk_keep <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a simple behavioural FIFO read port.
module tb_fifo_rd_packer;

    logic        rdclk;
    logic        rd_rst;
    logic        fifo_empty;
    logic        rd_en;
    logic [7:0]  data_out;
    logic        flush;
    logic [31:0] pk_data;
    logic [3:0]  pk_keep;
    logic        pk_valid;
    logic        pk_ready;

    logic [7:0]  mem [0:255];
    int          wr_ptr;
    int          rd_ptr;
    logic        hold_empty;
    int          cyc;

    int          total;
    int          bad;

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK_NUM(4)) dut (
        .rdclk      (rdclk),
        .rd_rst     (rd_rst),
        .fifo_empty (fifo_empty),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .flush      (flush),
        .pk_data    (pk_data),
        .pk_keep    (pk_keep),
        .pk_valid   (pk_valid),
        .pk_ready   (pk_ready)
    );

    initial rdclk = 1'b0;
    always #5 rdclk = ~rdclk;

    assign fifo_empty = (wr_ptr == rd_ptr) || hold_empty;

    // FIFO read port: one-cycle read latency.
    always @(posedge rdclk) begin
        cyc <= cyc + 1;
        if (rd_en && !fifo_empty) begin
            data_out <= mem[rd_ptr % 256];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr % 256] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    // Waits at negedges for pk_valid, bounded; returns the presented word.
    task automatic wait_word(input string tag, output logic [31:0] d, output logic [3:0] k);
        for (int i = 0; i < 60; i++) begin
            @(negedge rdclk);
            if (pk_valid) break;
        end
        check({tag, "_valid"}, {31'd0, pk_valid}, 32'd1);
        d = pk_data;
        k = pk_keep;
    endtask

    logic [31:0] d;
    logic [3:0]  k;
    int          t_first;
    int          snap_ptr;
    int          unstable;
    int          got_n;
    int          errs;
    logic [7:0]  exp_b;

    initial begin
        total = 0; bad = 0;
        wr_ptr = 0; rd_ptr = 0; cyc = 0;
        data_out = 8'h00;
        hold_empty = 1'b0;
        flush = 1'b0;
        pk_ready = 1'b1;
        rd_rst = 1'b1;

        // Reset state with a non-empty FIFO: no pops while reset is high.
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (3) @(negedge rdclk);
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_valid", {31'd0, pk_valid}, 32'd0);
        check("rst_keep", {28'd0, pk_keep}, 32'd0);
        check("rst_data", pk_data, 32'd0);

        // Two full words back to back.
        rd_rst = 1'b0;
        wait_word("w1", d, k);
        t_first = cyc;
        check("w1_data", d, 32'h04030201);
        check("w1_keep", {28'd0, k}, 32'hF);
        wait_word("w2", d, k);
        check("w2_data", d, 32'h08070605);
        check("w2_keep", {28'd0, k}, 32'hF);
        check("throughput", cyc - t_first, 32'd6);

        // Three entries then empty, flush pulse forces a partial word.
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (10) @(negedge rdclk);
        check("part_valid", {31'd0, pk_valid}, 32'd0);
        check("part_keep", {28'd0, pk_keep}, 32'h7);
        flush = 1'b1;
        @(negedge rdclk);
        flush = 1'b0;
        wait_word("fl", d, k);
        check("fl_data", d & 32'h00FFFFFF, 32'h00A3A2A1);
        check("fl_keep", {28'd0, k}, 32'h7);
        repeat (5) @(negedge rdclk);
        check("fl_no_pop", rd_ptr, 32'd11);

        // Backpressure: full word held for 20 cycles, one extra entry waits.
        pk_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        wait_word("bp", d, k);
        check("bp_data", d, 32'h14131211);
        snap_ptr = rd_ptr;
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge rdclk);
            if (pk_data !== 32'h14131211 || pk_keep !== 4'hF || !pk_valid || rd_en)
                unstable++;
        end
        check("bp_stable", unstable, 32'd0);
        check("bp_level", rd_ptr, snap_ptr);
        pk_ready = 1'b1;
        @(negedge rdclk);
        push(8'h16); push(8'h17); push(8'h18);
        wait_word("bp2", d, k);
        check("bp2_data", d, 32'h18171615);

        // Flush coincident with the second pop.
        hold_empty = 1'b1;
        push(8'h21); push(8'h22); push(8'h23);
        @(negedge rdclk);
        hold_empty = 1'b0;
        got_n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rd_en) begin
                got_n++;
                if (got_n == 2) begin
                    flush = 1'b1;
                    @(negedge rdclk);
                    flush = 1'b0;
                    break;
                end
            end
            @(negedge rdclk);
        end
        wait_word("f2", d, k);
        check("f2_data", d & 32'h0000FFFF, 32'h00002221);
        check("f2_keep", {28'd0, k}, 32'h3);
        push(8'h24); push(8'h25); push(8'h26);
        wait_word("f3", d, k);
        check("f3_data", d, 32'h26252423);
        check("f3_keep", {28'd0, k}, 32'hF);

        // Reset mid-word discards the held lanes.
        push(8'h31); push(8'h32);
        repeat (10) @(negedge rdclk);
        check("mid_keep", {28'd0, pk_keep}, 32'h3);
        rd_rst = 1'b1;
        #1;
        check("mr_data", pk_data, 32'd0);
        check("mr_keep", {28'd0, pk_keep}, 32'd0);
        check("mr_rd_en", {31'd0, rd_en}, 32'd0);
        @(negedge rdclk);
        rd_rst = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
        wait_word("ar", d, k);
        check("ar_data", d, 32'h44434241);
        check("ar_keep", {28'd0, k}, 32'hF);

        // Random empty/ready toggling with a counting source.
        for (int i = 0; i < 64; i++) push(8'h80 + 8'(i));
        got_n = 0;
        errs = 0;
        exp_b = 8'h80;
        for (int c = 0; c < 3000 && got_n < 64; c++) begin
            @(negedge rdclk);
            pk_ready   = ($urandom_range(0, 2) != 0);
            hold_empty = ($urandom_range(0, 3) == 0);
            #1;
            if (pk_valid && pk_ready) begin
                if (pk_keep !== 4'hF) errs++;
                for (int l = 0; l < 4; l++) begin
                    if (pk_data[l*8 +: 8] !== exp_b) errs++;
                    exp_b = exp_b + 8'd1;
                    got_n++;
                end
            end
        end
        hold_empty = 1'b0;
        pk_ready = 1'b1;
        check("rnd_errs", errs, 32'd0);
        check("rnd_count", got_n, 32'd64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
